// File: rtl/mux_mult_pkg.sv
// Shared types and helpers for the sequential mux-row multiplier.
package mux_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Width of the row counter for a given operand width.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/mux_mult_seq_mux_pp_row.sv
// One partial-product row: a 2:1 mux picks the shifted multiplicand or zero,
// then the row is added to (or subtracted from) the running accumulator.
module mux_pp_row
    import mux_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0]        x,
    input  logic [2*WIDTH-1:0]        acc,
    input  logic                      sel,
    input  logic [cnt_w(WIDTH)-1:0]   shift,
    input  logic                      sub,
    output logic [2*WIDTH-1:0]        acc_next
);

    logic [2*WIDTH-1:0] row;

    // Mux row, then accumulate; the result wraps at 2*WIDTH bits.
    always_comb begin
        row      = sel ? (x << shift) : '0;
        acc_next = sub ? (acc - row) : (acc + row);
    end

endmodule

// File: rtl/mux_mult_seq.sv
// Sequential WIDTH x WIDTH multiplier, one mux-selected row per cycle,
// with valid/ready on both sides.
// Build option: define MUX_MULT_SIGNED_EN for two's complement operands.
module mux_mult_seq
    import mux_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mult_state_t          state_q, state_d;
    logic [2*WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 last_row;
    logic                 sub_row;
    logic                 accept;
    logic [2*WIDTH-1:0]   x_ext;

    assign last_row = (cnt_q == LAST);

`ifdef MUX_MULT_SIGNED_EN
    // The top multiplier bit carries negative weight, so its row is subtracted.
    assign x_ext   = {{WIDTH{a[WIDTH-1]}}, a};
    assign sub_row = last_row;
`else
    assign x_ext   = {{WIDTH{1'b0}}, a};
    assign sub_row = 1'b0;
`endif

    mux_pp_row #(.WIDTH(WIDTH)) u_row (
        .x        (x_q),
        .acc      (acc_q),
        .sel      (y_q[cnt_q]),
        .shift    (cnt_q),
        .sub      (sub_row),
        .acc_next (acc_next)
    );

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        accept    = in_valid && in_ready;
        out_valid = (state_q == DONE);
        busy      = (state_q == CALC);
        p         = acc_q;

        case (state_q)
            IDLE: ;
            CALC: begin
                acc_d = acc_next;
                cnt_d = cnt_q + CW'(1);
                if (last_row) state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A new operand pair overrides everything, including a retire in DONE.
        if (accept) begin
            x_d     = x_ext;
            y_d     = b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux_mult_seq.sv
// Bench for mux_mult_seq: one WIDTH=4 and one WIDTH=8 instance, only one
// driven at a time; the idle instance sees in_valid=0 and out_ready=1.
module tb_mux_mult_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit         sel8;
    logic       t_iv;
    logic       t_ordy;
    logic [7:0] t_a, t_b;

    logic       in_ready4, out_valid4, busy4;
    logic [7:0] p4;
    logic       in_ready8, out_valid8, busy8;
    logic [15:0] p8;

    mux_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(!sel8 && t_iv), .in_ready(in_ready4),
        .a(t_a[3:0]), .b(t_b[3:0]),
        .out_valid(out_valid4), .out_ready(sel8 ? 1'b1 : t_ordy),
        .p(p4), .busy(busy4)
    );

    mux_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sel8 && t_iv), .in_ready(in_ready8),
        .a(t_a), .b(t_b),
        .out_valid(out_valid8), .out_ready(sel8 ? t_ordy : 1'b1),
        .p(p8), .busy(busy8)
    );

    wire        cur_ir   = sel8 ? in_ready8  : in_ready4;
    wire        cur_ov   = sel8 ? out_valid8 : out_valid4;
    wire        cur_busy = sel8 ? busy8      : busy4;
    wire [15:0] cur_p    = sel8 ? p8         : {8'h00, p4};

    // Reference product: plain integer multiply of the w-bit operands.
    function automatic logic [15:0] model(input int w, input logic [7:0] a,
                                          input logic [7:0] b);
        longint m, sa, sb;
        m  = longint'(1) << w;
        sa = longint'(a) & (m - 1);
        sb = longint'(b) & (m - 1);
`ifdef MUX_MULT_SIGNED_EN
        if (sa >= m / 2) sa = sa - m;
        if (sb >= m / 2) sb = sb - m;
`endif
        return 16'((sa * sb) & (m * m - 1));
    endfunction

    // One full transaction with optional output stall.
    task automatic do_op(input bit w8, input logic [7:0] a, input logic [7:0] b,
                         input int stall, output logic [15:0] got);
        int w, n;
        logic [15:0] exp;
        w = w8 ? 8 : 4;
        exp = model(w, a, b);
        @(negedge clk);
        sel8 = w8; t_iv = 1'b1; t_a = a; t_b = b; t_ordy = (stall == 0);
        #1;
        checks++;
        if (cur_ir !== 1'b1) begin
            errors++; $display("FAIL accept_ready w=%0d got %b want 1", w, cur_ir);
        end
        @(posedge clk);
        @(negedge clk);
        t_iv = 1'b0; t_a = 8'($urandom); t_b = 8'($urandom);
        n = 1;
        checks++;
        if (cur_busy !== 1'b1) begin
            errors++; $display("FAIL busy_calc w=%0d got %b want 1", w, cur_busy);
        end
        while (cur_ov !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != w + 1) begin
            errors++; $display("FAIL latency w=%0d got %0d want %0d", w, n, w + 1);
        end
        got = cur_p;
        checks++;
        if (cur_p !== exp) begin
            errors++;
            $display("FAIL product w=%0d a=%0d b=%0d got %0d want %0d", w, a, b, cur_p, exp);
        end
        for (int i = 0; i < stall; i++) begin
            checks++;
            if (cur_ov !== 1'b1 || cur_p !== exp || cur_ir !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold w=%0d ov=%b p=%0d ir=%b want 1 %0d 0",
                         w, cur_ov, cur_p, cur_ir, exp);
            end
            @(negedge clk);
        end
        if (stall > 0) begin
            t_ordy = 1'b1;
            #1;
            checks++;
            if (cur_ir !== 1'b1 || cur_ov !== 1'b1) begin
                errors++;
                $display("FAIL release_ready w=%0d ir=%b ov=%b want 1 1", w, cur_ir, cur_ov);
            end
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        checks++;
        if (cur_ov !== 1'b0 || cur_ir !== 1'b1) begin
            errors++;
            $display("FAIL retire w=%0d ov=%b ir=%b want 0 1", w, cur_ov, cur_ir);
        end
    endtask

    task automatic test_reset();
        sel8 = 1'b0; t_iv = 1'b0; t_ordy = 1'b1; t_a = '0; t_b = '0;
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid4 !== 1'b0 || p4 !== 8'h0 || busy4 !== 1'b0 ||
            out_valid8 !== 1'b0 || p8 !== 16'h0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state ov=%b%b p=%0d,%0d busy=%b%b want zeros",
                     out_valid4, out_valid8, p4, p8, busy4, busy8);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready4 !== 1'b1 || in_ready8 !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b%b want 11", in_ready4, in_ready8);
        end
    endtask

    task automatic test_basic();
        logic [15:0] got;
        do_op(1'b0, 8'd15, 8'd15, 0, got);
`ifndef MUX_MULT_SIGNED_EN
        checks++;
        if (got !== 16'd225) begin
            errors++; $display("FAIL basic_15x15 got %0d want 225", got);
        end
`endif
    endtask

    task automatic test_zero();
        logic [15:0] got;
        do_op(1'b0, 8'd0, 8'd9, 0, got);
        checks++;
        if (got !== 16'd0) begin
            errors++; $display("FAIL zero_a got %0d want 0", got);
        end
        do_op(1'b0, 8'd9, 8'd0, 0, got);
        checks++;
        if (got !== 16'd0) begin
            errors++; $display("FAIL zero_b got %0d want 0", got);
        end
    endtask

    task automatic test_stall();
        logic [15:0] got;
        do_op(1'b1, 8'd200, 8'd123, 10, got);
`ifndef MUX_MULT_SIGNED_EN
        checks++;
        if (got !== 16'd24600) begin
            errors++; $display("FAIL stall_200x123 got %0d want 24600", got);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [7:0] oa [3];
        logic [7:0] ob [3];
        int prev, n;
        oa[0] = 8'd3;   ob[0] = 8'd7;
        oa[1] = 8'd255; ob[1] = 8'd255;
        oa[2] = 8'd16;  ob[2] = 8'd16;
        @(negedge clk);
        sel8 = 1'b1; t_ordy = 1'b1; t_iv = 1'b1; t_a = oa[0]; t_b = ob[0];
        prev = cyc;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            // in_valid stays high during CALC; these operands must be ignored.
            t_a = 8'($urandom); t_b = 8'($urandom);
            n = 0;
            while (cur_ov !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (cur_p !== model(8, oa[k], ob[k])) begin
                errors++;
                $display("FAIL b2b_product k=%0d got %0d want %0d", k, cur_p,
                         model(8, oa[k], ob[k]));
            end
            checks++;
            if (cyc - prev != 9) begin
                errors++; $display("FAIL b2b_spacing k=%0d got %0d want 9", k, cyc - prev);
            end
            prev = cyc;
            if (k < 2) begin
                t_a = oa[k+1]; t_b = ob[k+1];
            end else begin
                t_iv = 1'b0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (cur_ov !== 1'b0 || cur_ir !== 1'b1) begin
            errors++; $display("FAIL b2b_end ov=%b ir=%b want 0 1", cur_ov, cur_ir);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got;
        bit seen;
        @(negedge clk);
        sel8 = 1'b0; t_ordy = 1'b1; t_iv = 1'b1; t_a = 8'd11; t_b = 8'd13;
        @(posedge clk);
        @(negedge clk);
        t_iv = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid4 !== 1'b0 || p4 !== 8'h0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset ov=%b p=%0d busy=%b want 0 0 0", out_valid4, p4, busy4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (out_valid4 !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL mid_reset_spurious got out_valid=1 want 0");
        end
        do_op(1'b0, 8'd5, 8'd6, 0, got);
`ifndef MUX_MULT_SIGNED_EN
        checks++;
        if (got !== 16'd30) begin
            errors++; $display("FAIL after_reset_5x6 got %0d want 30", got);
        end
`endif
    endtask

    task automatic test_random();
        logic [15:0] got;
        for (int i = 0; i < 16; i++) begin
            do_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  int'($urandom_range(0, 3)), got);
        end
    endtask

`ifdef MUX_MULT_SIGNED_EN
    task automatic test_signed();
        logic [15:0] got;
        do_op(1'b0, 8'h8, 8'h8, 0, got);
        checks++;
        if (got[7:0] !== 8'h40) begin
            errors++; $display("FAIL signed_m8xm8 got %h want 40", got[7:0]);
        end
        do_op(1'b0, 8'h8, 8'h7, 0, got);
        checks++;
        if (got[7:0] !== 8'hC8) begin
            errors++; $display("FAIL signed_m8x7 got %h want c8", got[7:0]);
        end
        do_op(1'b0, 8'hF, 8'h1, 1, got);
        checks++;
        if (got[7:0] !== 8'hFF) begin
            errors++; $display("FAIL signed_m1x1 got %h want ff", got[7:0]);
        end
        do_op(1'b0, 8'h7, 8'h7, 0, got);
        checks++;
        if (got[7:0] !== 8'h31) begin
            errors++; $display("FAIL signed_7x7 got %h want 31", got[7:0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef MUX_MULT_SIGNED_EN
        test_signed();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
